// File: rtl/blowfish128_pkg.sv
// Shared constants and state encoding for the Blowfish-128 engine front-end.
package blowfish128_pkg;

    localparam int BLOCK_W = 128;
    localparam int WD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/blowfish128_arbiter_if.sv
// Client, response and engine-side signal bundle of the Blowfish-128 arbiter.
interface blowfish128_arbiter_if;
    import blowfish128_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic               req0_encrypt;
    logic [BLOCK_W-1:0] req0_data;

    logic               req1_valid;
    logic               req1_ready;
    logic               req1_encrypt;
    logic [BLOCK_W-1:0] req1_data;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic               rsp_err;
    logic [BLOCK_W-1:0] rsp_data;

    logic               eng_enable;
    logic               eng_encrypt;
    logic [BLOCK_W-1:0] eng_plaintext;
    logic [BLOCK_W-1:0] eng_ciphertext;
    logic               eng_ready;

    logic               busy;

    // The arbiter itself connects through the slave view.
    modport slave (
        input  req0_valid, req0_encrypt, req0_data,
        input  req1_valid, req1_encrypt, req1_data,
        input  rsp_ready, eng_ciphertext, eng_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_err, rsp_data,
        output eng_enable, eng_encrypt, eng_plaintext, busy
    );

    modport master (
        output req0_valid, req0_encrypt, req0_data,
        output req1_valid, req1_encrypt, req1_data,
        output rsp_ready, eng_ciphertext, eng_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_err, rsp_data,
        input  eng_enable, eng_encrypt, eng_plaintext, busy
    );

endinterface

// File: rtl/blowfish128_rr_arb.sv
// Combinational two-way round-robin picker: one-hot grant over the valid
// requesters, favouring the one that did not win last time.
module blowfish128_rr_arb (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/blowfish128_arbiter.sv
// Shares one Blowfish-128 engine between two requesters: round-robin accept,
// single engine run bounded by a watchdog, tagged response with backpressure.
module blowfish128_arbiter
    import blowfish128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   Clk,
    input  logic                   RstN,
    blowfish128_arbiter_if.slave   bus
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic               lastGrant_q, lastGrant_d;
    logic [WD_W-1:0]    wdCount_q, wdCount_d;
    logic               jobEnc_q, jobEnc_d;
    logic               jobId_q, jobId_d;
    logic [BLOCK_W-1:0] jobData_q, jobData_d;
    logic               rspErr_q, rspErr_d;
    logic [BLOCK_W-1:0] rspData_q, rspData_d;

    logic [1:0]         grant;
    logic               accept;
    logic               wdExpired;

    blowfish128_rr_arb u_rr_arb (
        .valid_i      ({bus.req1_valid, bus.req0_valid}),
        .last_grant_i (lastGrant_q),
        .grant_o      (grant)
    );

    assign accept    = (state_q == ST_IDLE) && (grant != 2'b00);
    assign wdExpired = (wdCount_q == WD_LIMIT);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // eng_ready takes priority over an expiring watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (bus.eng_ready || wdExpired) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lastGrant_d = lastGrant_q;
        wdCount_d   = wdCount_q;
        jobEnc_d    = jobEnc_q;
        jobId_d     = jobId_q;
        jobData_d   = jobData_q;
        rspErr_d    = rspErr_q;
        rspData_d   = rspData_q;

        if (accept) begin
            jobId_d     = grant[1];
            jobEnc_d    = grant[1] ? bus.req1_encrypt : bus.req0_encrypt;
            jobData_d   = grant[1] ? bus.req1_data    : bus.req0_data;
            lastGrant_d = grant[1];
            wdCount_d   = '0;
        end

        if (state_q == ST_RUN) begin
            wdCount_d = wdCount_q + WD_W'(1);
            if (bus.eng_ready) begin
                rspData_d = bus.eng_ciphertext;
                rspErr_d  = 1'b0;
            end else if (wdExpired) begin
                rspData_d = '0;
                rspErr_d  = 1'b1;
            end
        end
    end

    // Last grant resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            lastGrant_q <= 1'b1;
            wdCount_q   <= '0;
            jobEnc_q    <= 1'b0;
            jobId_q     <= 1'b0;
            jobData_q   <= '0;
            rspErr_q    <= 1'b0;
            rspData_q   <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            wdCount_q   <= wdCount_d;
            jobEnc_q    <= jobEnc_d;
            jobId_q     <= jobId_d;
            jobData_q   <= jobData_d;
            rspErr_q    <= rspErr_d;
            rspData_q   <= rspData_d;
        end
    end

    always_comb begin
        bus.req0_ready    = (state_q == ST_IDLE) && grant[0];
        bus.req1_ready    = (state_q == ST_IDLE) && grant[1];
        bus.rsp_valid     = (state_q == ST_RESP);
        bus.rsp_id        = jobId_q;
        bus.rsp_err       = rspErr_q;
        bus.rsp_data      = rspData_q;
        bus.eng_enable    = (state_q == ST_RUN);
        bus.eng_encrypt   = jobEnc_q;
        bus.eng_plaintext = jobData_q;
        bus.busy          = (state_q != ST_IDLE);
    end

endmodule

// File: doc/blowfish128_arbiter.md
# blowfish128_arbiter

Two-requester round-robin arbiter and sequencer that shares one Blowfish-128 engine (`blowfish128_top` instance) between independent clients. It accepts 128-bit blocks with an encrypt/decrypt flag from either requester and drives the engine's Enable/Encrypt/plainText inputs. It waits for cipherReady and returns the result on a single tagged response port with backpressure. A watchdog bounds each engine run. The block sits between the client interfaces and the engine; key inputs go to the engine directly and are not handled here.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles `eng_enable` stays high awaiting `eng_ready` before an error response; legal range 2..65535.
- `Clk` in 1: single clock; all logic is rising-edge.
- `RstN` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 holds a block.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_encrypt` in 1: requester 0 direction; 1 = encrypt, 0 = decrypt.
- `req0_data` in 128: requester 0 block.
- `req1_valid`, `req1_ready`, `req1_encrypt`, `req1_data`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester index that owns the response.
- `rsp_err` out 1: response produced by watchdog timeout.
- `rsp_data` out 128: engine result; zero when `rsp_err`=1.
- `eng_enable` out 1: to engine Enable.
- `eng_encrypt` out 1: to engine Encrypt.
- `eng_plaintext` out 128: to engine plainText.
- `eng_ciphertext` in 128: from engine cipherText.
- `eng_ready` in 1: from engine cipherReady.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - `reqN_ready` is combinational: high only for the selected requester, and only when that requester's valid is high.
  - Arbitration:
    - Only one requester valid: it wins.
    - Both valid: the requester that is not `last_grant` wins.
  - On the handshake, register the winner's data, direction and id, update `last_grant`, clear the watchdog, and go to RUN.
- **RUN**
  - `eng_enable`=1; `eng_encrypt` and `eng_plaintext` are held from the registered values.
  - Watchdog increments each cycle.
  - On `eng_ready`=1: capture `eng_ciphertext` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Watchdog reaches `TIMEOUT_CYCLES`-1 with `eng_ready`=0: set `rsp_data`=0, set `rsp_err`=1, go to RESP.
  - `eng_ready` and the timeout in the same cycle: `eng_ready` wins, and `rsp_err`=0.
- **RESP**
  - `eng_enable`=0 and `rsp_valid`=1.
  - `rsp_id`, `rsp_err` and `rsp_data` stay stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE.
  - Because of RESP, `eng_enable` is low for at least one cycle between jobs, so the engine always sees a fresh rising Enable.
- `eng_ready` is ignored in IDLE and RESP.
- `reqN_ready` is 0 outside IDLE.
- **Reset values:** state IDLE, `last_grant`=1 (requester 0 wins the first contention). All outputs are 0: `reqN_ready`, `rsp_valid`, `rsp_id`, `rsp_err`, `rsp_data`, `eng_enable`, `eng_encrypt`, `eng_plaintext`, `busy`.
- **Reset mid-operation:** asynchronous return to reset values. `eng_enable` drops immediately and any in-flight job is discarded without a response.

## Timing
- Acceptance is cycle A, with `reqN_ready` && `reqN_valid`.
- `eng_enable` rises at A+1.
- When the engine raises `eng_ready` at cycle E, `rsp_valid` rises at E+1 and `eng_enable` falls at E+1.
- With `rsp_ready` tied high, the earliest next acceptance is E+2.
- Throughput is one job per (engine latency + 3) cycles.
- A timeout response appears at A+1+`TIMEOUT_CYCLES`.
- No combinational path from `eng_*` inputs or `rsp_ready` to any output. `reqN_ready` depends only on the state, the `reqN_valid` inputs and `last_grant`.

## Structure
- Shared package `blowfish128_pkg` holds:
  - the state encoding constants (IDLE, RUN, RESP);
  - the block-width constant 128;
  - the watchdog counter width, 16.
- Sub-module `blowfish128_rr_arb`: combinational 2-way round-robin picker (valid[1:0], last_grant → grant one-hot). It is reused by later multi-client wrappers.
- The FSM, data registers and watchdog live in `blowfish128_arbiter`.

## Test plan
- **Single request:** `req0` encrypt, data 128'h0123…CDEF; engine model asserts `eng_ready` 20 cycles after Enable. Required: `eng_enable` rises at A+1; `rsp_valid` rises at E+1 with `rsp_id`=0, `rsp_err`=0 and the model's ciphertext.
- **Contention:** `req0` and `req1` both valid continuously for 4 jobs. Required grant order 0,1,0,1; the `rsp_id` sequence matches.
- **Backpressure:** `rsp_ready` held 0 for 10 cycles in RESP. Required: `rsp_*` stable, `req*_ready`=0, `eng_enable`=0; acceptance resumes the cycle after `rsp_ready`.
- **Timeout:** `TIMEOUT_CYCLES`=8, engine never ready. Required: `rsp_err`=1 and `rsp_data`=0 at A+9; the next job proceeds normally.
- **Edge collision:** `eng_ready` coincides with the watchdog limit. Required: `rsp_err`=0 and the ciphertext is returned.
- **Reset mid-RUN:** `RstN` low for 1 cycle during RUN. Required: all outputs 0 asynchronously, no response emitted, and after release `req0` wins first contention.
